// File: rtl/stereolbm_axis_cambm_mul_arbiter.sv
// stereolbm_axis_cambm_mul_arbiter: round-robin shared unsigned multiplier with tagged, stallable result pipeline
module stereolbm_axis_cambm_mul_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int DIN0_W  = 5,
   parameter int DIN1_W  = 5,
   parameter int DOUT_W  = 10,
   parameter int LAT     = 1
) (
   input  logic                       ap_clk,
   input  logic                       ap_rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*DIN0_W-1:0]  req_din0,
   input  logic [NUM_REQ*DIN1_W-1:0]  req_din1,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [DOUT_W-1:0]          res_dout,
   output logic [ID_W-1:0]            res_id
);
   logic               en;
   logic               gnt_any;
   logic [ID_W-1:0]    gnt_idx;
   logic [ID_W-1:0]    cand;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [DIN0_W-1:0]  op0;
   logic [DIN1_W-1:0]  op1;
   logic [DOUT_W-1:0]  prod;
   logic [LAT-1:0]     vld_q, vld_d;
   logic [ID_W-1:0]    id_q [LAT];
   logic [ID_W-1:0]    id_d [LAT];
   logic [DOUT_W-1:0]  dat_q [LAT];
   logic [DOUT_W-1:0]  dat_d [LAT];

   assign res_valid = vld_q[LAT-1];
   assign res_id    = id_q[LAT-1];
   assign res_dout  = dat_q[LAT-1];
   assign en        = !res_valid || res_ready;

   // Round-robin scan from rr_ptr; the grant is suppressed while stalled or in reset
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!gnt_any && req_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
      gnt_any   = gnt_any && en && !ap_rst;
      req_ready = gnt_any ? NUM_REQ'(1) << gnt_idx : '0;
      op0       = req_din0[gnt_idx*DIN0_W +: DIN0_W];
      op1       = req_din1[gnt_idx*DIN1_W +: DIN1_W];
      prod      = DOUT_W'(op0) * DOUT_W'(op1);
      rr_ptr_d  = gnt_any ? (gnt_idx == ID_W'(NUM_REQ-1) ? '0 : gnt_idx + ID_W'(1)) : rr_ptr_q;
   end

   // All stages advance together on en; stage 0 takes the granted product or a bubble
   always_comb begin
      vld_d = vld_q;
      id_d  = id_q;
      dat_d = dat_q;
      if (en) begin
         vld_d[0] = gnt_any;
         id_d[0]  = gnt_idx;
         dat_d[0] = prod;
         for (int s = 1; s < LAT; s++) begin
            vld_d[s] = vld_q[s-1];
            id_d[s]  = id_q[s-1];
            dat_d[s] = dat_q[s-1];
         end
      end
   end

   // State registers; reset drops every in-flight result and rewinds the pointer
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         rr_ptr_q <= '0;
         vld_q    <= '0;
         for (int s = 0; s < LAT; s++) begin
            id_q[s]  <= '0;
            dat_q[s] <= '0;
         end
      end else begin
         rr_ptr_q <= rr_ptr_d;
         vld_q    <= vld_d;
         id_q     <= id_d;
         dat_q    <= dat_d;
      end
   end
endmodule

// File: tb/tb_stereolbm_axis_cambm_mul_arbiter.sv
// tb_stereolbm_axis_cambm_mul_arbiter: table-driven grant checks plus scoreboard on tagged products
module tb_stereolbm_axis_cambm_mul_arbiter;
   typedef struct {
      logic [3:0]  rv;
      logic [19:0] d0;
      logic [19:0] d1;
      logic        rr;
      logic [3:0]  er;
      logic        ev;
   } vec_t;
   typedef struct {
      logic [1:0] id;
      logic [9:0] dout;
   } exp_t;

   localparam logic [19:0] D0 = {5'd4, 5'd3, 5'd2, 5'd1};
   localparam logic [19:0] D1 = {5'd10, 5'd9, 5'd8, 5'd7};

   logic        ap_clk = 1'b0;
   logic        ap_rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [19:0] req_din0 = '0;
   logic [19:0] req_din1 = '0;
   logic        res_ready = 1'b1;
   logic [3:0]  rdy1, rdy2;
   logic        rv1, rv2;
   logic [9:0]  dout1, dout2;
   logic [1:0]  id1, id2;

   int   n_chk = 0;
   int   n_fail = 0;
   vec_t tbl[$];
   exp_t sb[$];
   exp_t e_m;

   always #5 ap_clk = ~ap_clk;

   stereolbm_axis_cambm_mul_arbiter #(.NUM_REQ(4), .ID_W(2), .DIN0_W(5), .DIN1_W(5), .DOUT_W(10), .LAT(1)) u_dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .req_valid(req_valid), .req_ready(rdy1),
      .req_din0(req_din0), .req_din1(req_din1), .res_valid(rv1), .res_ready(res_ready),
      .res_dout(dout1), .res_id(id1));

   stereolbm_axis_cambm_mul_arbiter #(.NUM_REQ(4), .ID_W(2), .DIN0_W(5), .DIN1_W(5), .DOUT_W(10), .LAT(2)) u_dut2 (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .req_valid(req_valid), .req_ready(rdy2),
      .req_din0(req_din0), .req_din1(req_din1), .res_valid(rv2), .res_ready(res_ready),
      .res_dout(dout2), .res_id(id2));

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] rv, input logic [19:0] d0, input logic [19:0] d1,
                               input logic rr, input logic [3:0] er, input logic ev);
      vec_t v;
      v.rv = rv; v.d0 = d0; v.d1 = d1; v.rr = rr; v.er = er; v.ev = ev;
      return v;
   endfunction

   // Scoreboard: pop on each output transfer, push on each accepted request of the LAT=1 instance
   always @(negedge ap_clk) begin
      if (ap_rst) sb.delete();
      else begin
         if (rv1 && res_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
               e_m = sb.pop_front();
               chk("res_dout", int'(dout1), int'(e_m.dout));
               chk("res_id", int'(id1), int'(e_m.id));
            end
         end
         for (int i = 0; i < 4; i++)
            if (req_valid[i] && rdy1[i])
               sb.push_back('{2'(i), 10'(req_din0[i*5 +: 5]) * 10'(req_din1[i*5 +: 5])});
      end
   end

   task automatic cyc(input logic rst, input logic [3:0] rv, input logic rr);
      @(posedge ap_clk);
      #1;
      ap_rst = rst; req_valid = rv; res_ready = rr;
      @(negedge ap_clk);
   endtask

   initial begin
      tbl.push_back(mk(4'b0001, 20'd31, 20'd31, 1, 4'b0001, 0));
      tbl.push_back(mk(4'b0000, D0, D1, 1, 4'b0000, 1));
      tbl.push_back(mk(4'b1111, D0, D1, 1, 4'b0010, 0));
      tbl.push_back(mk(4'b1111, D0, D1, 1, 4'b0100, 1));
      tbl.push_back(mk(4'b1111, D0, D1, 1, 4'b1000, 1));
      tbl.push_back(mk(4'b1111, D0, D1, 1, 4'b0001, 1));
      tbl.push_back(mk(4'b1111, D0, D1, 1, 4'b0010, 1));
      tbl.push_back(mk(4'b0000, D0, D1, 1, 4'b0000, 1));
      tbl.push_back(mk(4'b0100, D0, D1, 1, 4'b0100, 0));
      tbl.push_back(mk(4'b1010, D0, D1, 1, 4'b1000, 1));
      tbl.push_back(mk(4'b1010, D0, D1, 1, 4'b0010, 1));
      tbl.push_back(mk(4'b1010, D0, D1, 1, 4'b1000, 1));
      tbl.push_back(mk(4'b0000, D0, D1, 1, 4'b0000, 1));
      tbl.push_back(mk(4'b0001, {15'd0, 5'd0}, {15'd0, 5'd31}, 1, 4'b0001, 0));
      tbl.push_back(mk(4'b0010, {10'd0, 5'd31, 5'd0}, {10'd0, 5'd1, 5'd0}, 1, 4'b0010, 1));
      tbl.push_back(mk(4'b0100, {5'd0, 5'd16, 10'd0}, {5'd0, 5'd16, 10'd0}, 1, 4'b0100, 1));
      tbl.push_back(mk(4'b0000, D0, D1, 1, 4'b0000, 1));
      tbl.push_back(mk(4'b1111, D0, D1, 1, 4'b1000, 0));
      tbl.push_back(mk(4'b1111, D0, D1, 0, 4'b0000, 1));
      tbl.push_back(mk(4'b1111, D0, D1, 0, 4'b0000, 1));
      tbl.push_back(mk(4'b1111, D0, D1, 0, 4'b0000, 1));
      tbl.push_back(mk(4'b1111, D0, D1, 1, 4'b0001, 1));
      tbl.push_back(mk(4'b0000, D0, D1, 1, 4'b0000, 1));
      tbl.push_back(mk(4'b0000, D0, D1, 1, 4'b0000, 0));

      req_valid = 4'b1111;
      req_din0  = D0;
      req_din1  = D1;
      repeat (2) @(posedge ap_clk);
      @(negedge ap_clk);
      chk("rst_res_valid", int'(rv1), 0);
      chk("rst_res_dout", int'(dout1), 0);
      chk("rst_res_id", int'(id1), 0);
      chk("rst_req_ready", int'(rdy1), 0);

      for (int r = 0; r < tbl.size(); r++) begin
         @(posedge ap_clk);
         #1;
         ap_rst = 1'b0; req_valid = tbl[r].rv; req_din0 = tbl[r].d0;
         req_din1 = tbl[r].d1; res_ready = tbl[r].rr;
         @(negedge ap_clk);
         chk($sformatf("req_ready row %0d", r), int'(rdy1), int'(tbl[r].er));
         chk($sformatf("res_valid row %0d", r), int'(rv1), int'(tbl[r].ev));
      end

      req_din0 = D0;
      req_din1 = D1;
      cyc(1, 4'b1111, 1);
      chk("ready_in_rst", int'(rdy1), 0);
      chk("ready_in_rst_lat2", int'(rdy2), 0);
      cyc(0, 4'b1111, 1);
      chk("post_rst_grant", int'(rdy1), 1);
      chk("post_rst_grant_lat2", int'(rdy2), 1);
      chk("post_rst_valid", int'(rv1), 0);
      cyc(0, 4'b1111, 1);
      chk("lat2_second_grant", int'(rdy2), 2);
      chk("lat2_not_yet_valid", int'(rv2), 0);
      cyc(1, 4'b0000, 1);
      chk("lat2_in_flight", int'(rv2), 1);
      chk("lat2_ready_in_rst", int'(rdy2), 0);
      cyc(0, 4'b0000, 1);
      chk("lat2_flush", int'(rv2), 0);
      chk("lat1_flush", int'(rv1), 0);
      cyc(0, 4'b0000, 1);
      chk("lat2_no_ghost", int'(rv2), 0);
      cyc(0, 4'b1111, 1);
      chk("lat2_ptr_rewound", int'(rdy2), 1);
      chk("lat1_ptr_rewound", int'(rdy1), 1);
      cyc(0, 4'b0000, 1);
      cyc(0, 4'b0000, 1);
      cyc(0, 4'b0000, 1);
      chk("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
